// File: rtl/lfsr_word_sampler_if.sv
// Word handshake between the LFSR sampler (master) and its random-number consumer (slave).
interface lfsr_word_sampler_if;
   logic        ready;
   logic        valid;
   logic [15:0] word;
   logic        health_fail;

   modport master (input ready, output valid, output word, output health_fail);
   modport slave  (output ready, input valid, input word, input health_fail);
endinterface

// File: rtl/lfsr_word_sampler.sv
// Captures the 16-bit LFSR state once it has fully refreshed and presents it on valid/ready.
// Optional repetition health test: define LFSR_WORD_SAMPLER_HEALTH_TEST_EN.
module lfsr_word_sampler #(
   parameter int REFRESH_CYCLES = 16,
   parameter int REP_LIMIT      = 3
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [15:0]          lfsr,
   lfsr_word_sampler_if.master  bus
);
   typedef enum logic [1:0] {SETTLE, COLLECT, PRESENT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(REFRESH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] word_q, word_d;

`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
   localparam logic [3:0] REP_MAX = 4'(REP_LIMIT);

   logic        hf_q, hf_d;
   logic        have_q, have_d;
   logic [15:0] prev_q, prev_d;
   logic [3:0]  rep_q, rep_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
      hf_d    = hf_q;
      have_d  = have_q;
      prev_d  = prev_q;
      rep_d   = rep_q;
`endif
      case (state_q)
         SETTLE: begin
            state_d = COLLECT;
            cnt_d   = '0;
         end
         COLLECT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
               // Once tripped, captures are dropped until reset.
               if (!hf_q) begin
                  rep_d  = (have_q && (lfsr == prev_q)) ? rep_q + 4'd1 : 4'd1;
                  prev_d = lfsr;
                  have_d = 1'b1;
                  if (rep_d == REP_MAX) begin
                     hf_d = 1'b1;
                  end else begin
                     word_d  = lfsr;
                     state_d = PRESENT;
                  end
               end
`else
               word_d  = lfsr;
               state_d = PRESENT;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         PRESENT: begin
            if (bus.ready) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         default: state_d = SETTLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= SETTLE;
         cnt_q   <= '0;
         word_q  <= '0;
`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
         hf_q    <= 1'b0;
         have_q  <= 1'b0;
         prev_q  <= '0;
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
         hf_q    <= hf_d;
         have_q  <= have_d;
         prev_q  <= prev_d;
         rep_q   <= rep_d;
`endif
      end
   end

   assign bus.valid = (state_q == PRESENT);
   assign bus.word  = word_q;
`ifdef LFSR_WORD_SAMPLER_HEALTH_TEST_EN
   assign bus.health_fail = hf_q;
`else
   // REP_LIMIT is at least 2 when legal, so this is a constant 0.
   assign bus.health_fail = (REP_LIMIT == 0);
`endif
endmodule
